// File: rtl/ram_access_ctrl.sv
// Synchronous front end for an asynchronous RAM.
// Takes one read or write request at a time over a valid/ready handshake.
// Write strobe timing is set by SETUP/PULSE/HOLD_CYCLES and read timing by READ_CYCLES.
// Address and data stay stable for the whole strobe window.
// Every output comes straight from a flop.
module ram_access_ctrl #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 1,
   parameter int READ_CYCLES  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_reqValid,
   output logic                  o_reqReady,
   input  logic                  i_reqWrite,
   input  logic [ADDR_WIDTH-1:0] i_reqAddress,
   input  logic [DATA_WIDTH-1:0] i_reqData,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_readData,
   output logic [ADDR_WIDTH-1:0] o_ramAddress,
   output logic                  o_ramWriteNEn,
   output logic [DATA_WIDTH-1:0] o_ramWriteData,
   input  logic [DATA_WIDTH-1:0] i_ramReadData,
   output logic                  o_ramNoe
);

   // The phase counter counts down to zero, so each phase loads its length minus one.
   localparam logic [7:0] S_LOAD = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] P_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] H_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] R_LOAD = 8'(READ_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS} state_t;

   state_t                state, state_nxt;
   logic [7:0]            cnt, cnt_nxt;
   logic                  ready_nxt, done_nxt, wen_nxt, noe_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;
   logic                  accept;

   assign accept = i_reqValid & o_reqReady;

   // Next state, phase timing and the next value of every registered output.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ready_nxt = o_reqReady;
      done_nxt  = 1'b0;
      wen_nxt   = o_ramWriteNEn;
      noe_nxt   = o_ramNoe;
      addr_nxt  = o_ramAddress;
      wdata_nxt = o_ramWriteData;
      rdata_nxt = o_readData;
      case (state)
         IDLE: begin
            // Ready comes up on the first edge after reset and stays up until an accept.
            ready_nxt = 1'b1;
            if (accept) begin
               ready_nxt = 1'b0;
               addr_nxt  = i_reqAddress;
               wdata_nxt = i_reqData;
               if (i_reqWrite) begin
                  state_nxt = W_SETUP;
                  cnt_nxt   = S_LOAD;
               end else begin
                  state_nxt = R_ACCESS;
                  cnt_nxt   = R_LOAD;
                  noe_nxt   = 1'b0;
               end
            end
         end
         W_SETUP: begin
            if (cnt == 8'd0) begin
               state_nxt = W_PULSE;
               cnt_nxt   = P_LOAD;
               wen_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         W_PULSE: begin
            if (cnt == 8'd0) begin
               state_nxt = W_HOLD;
               cnt_nxt   = H_LOAD;
               wen_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         W_HOLD: begin
            if (cnt == 8'd0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               ready_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         R_ACCESS: begin
            // Capture the RAM output on the edge that ends the last output-enable cycle.
            if (cnt == 8'd0) begin
               state_nxt = IDLE;
               noe_nxt   = 1'b1;
               rdata_nxt = i_ramReadData;
               done_nxt  = 1'b1;
               ready_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            ready_nxt = 1'b0;
            wen_nxt   = 1'b1;
            noe_nxt   = 1'b1;
         end
      endcase
   end

   // State and output registers; reset drops both strobes to inactive right away.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state          <= IDLE;
         cnt            <= 8'd0;
         o_reqReady     <= 1'b0;
         o_done         <= 1'b0;
         o_ramWriteNEn  <= 1'b1;
         o_ramNoe       <= 1'b1;
         o_ramAddress   <= '0;
         o_ramWriteData <= '0;
         o_readData     <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         o_reqReady     <= ready_nxt;
         o_done         <= done_nxt;
         o_ramWriteNEn  <= wen_nxt;
         o_ramNoe       <= noe_nxt;
         o_ramAddress   <= addr_nxt;
         o_ramWriteData <= wdata_nxt;
         o_readData     <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl.
// Directed steps are followed by random traffic. Each sample is checked against a
// cycle-by-cycle expectation built from the phase lengths and a memory scoreboard.
module tb_ram_access_ctrl;

   localparam int S = 1;
   localparam int P = 2;
   localparam int H = 1;
   localparam int R = 2;

   logic        clk = 1'b0;
   logic        nrst;
   logic        req_valid, req_write;
   logic [15:0] req_addr, req_data;
   logic        req_ready, done;
   logic [15:0] read_data, ram_addr, ram_wdata, ram_rdata;
   logic        ram_wen, ram_noe;

   logic [15:0] ram_mem [0:65535];
   logic [15:0] exp_mem [logic [15:0]];
   logic [15:0] exp_rdata, cur_addr, cur_wdata;
   int          total = 0;
   int          bad = 0;
   int          overlap = 0;

   always #5 clk = ~clk;

   ram_access_ctrl #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(S),
      .PULSE_CYCLES(P), .HOLD_CYCLES(H), .READ_CYCLES(R)
   ) dut (
      .i_clk(clk), .i_nrst(nrst), .i_reqValid(req_valid), .o_reqReady(req_ready),
      .i_reqWrite(req_write), .i_reqAddress(req_addr), .i_reqData(req_data),
      .o_done(done), .o_readData(read_data), .o_ramAddress(ram_addr),
      .o_ramWriteNEn(ram_wen), .o_ramWriteData(ram_wdata),
      .i_ramReadData(ram_rdata), .o_ramNoe(ram_noe)
   );

   // Asynchronous RAM model: stores while the write strobe is low, drives data while output-enable is low.
   always @(posedge clk) if (!ram_wen) ram_mem[ram_addr] <= ram_wdata;
   assign ram_rdata = ram_noe ? 16'h0000 : ram_mem[ram_addr];

   // Strobe overlap watcher.
   always @(negedge clk) if (!ram_wen && !ram_noe) overlap++;

   task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [51:0] sample();
      return {req_ready, done, ram_wen, ram_noe, ram_addr, ram_wdata, read_data};
   endfunction

   // Idle cycles: ready high, no done, strobes inactive, registers held.
   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("%s_idle%0d", tag, i), sample(),
               {1'b1, 1'b0, 1'b1, 1'b1, cur_addr, cur_wdata, exp_rdata});
      end
   endtask

   // Issue one request at a negedge where ready is expected high, then check every cycle up to done.
   // mode 0: valid low while busy; 1: random noise while busy; 2: hold valid with the next request.
   task automatic do_txn(input logic wr, input logic [15:0] a, input logic [15:0] d, input int mode,
                         input logic nwr, input logic [15:0] na, input logic [15:0] nd,
                         input string tag);
      int          n;
      logic        e_wen, e_noe, e_last;
      n = wr ? (S + P + H + 1) : (R + 1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
      if (wr) exp_mem[a] = d;
      cur_addr = a; cur_wdata = d;
      @(posedge clk);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         e_last = (k == n);
         e_wen  = (wr && k >= S + 1 && k <= S + P) ? 1'b0 : 1'b1;
         e_noe  = (!wr && k <= R) ? 1'b0 : 1'b1;
         if (!wr && e_last) exp_rdata = exp_mem[a];
         check($sformatf("%s_c%0d", tag, k), sample(),
               {e_last, e_last, e_wen, e_noe, a, d, exp_rdata});
         if (mode == 2) begin
            req_valid = 1'b1; req_write = nwr; req_addr = na; req_data = nd;
         end else if (mode == 1 && !e_last) begin
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_addr = 16'($urandom); req_data = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
      end
   endtask

   initial begin
      logic [15:0] addrs [5];
      logic [15:0] d2;
      addrs[0] = 16'h0012; addrs[1] = 16'hFFFF; addrs[2] = 16'h0000;
      addrs[3] = 16'h00A5; addrs[4] = 16'h8000;
      nrst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
      exp_rdata = '0; cur_addr = '0; cur_wdata = '0;

      // 1: reset held, then released
      repeat (3) @(negedge clk);
      check("reset_hold", sample(), {1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0});
      nrst = 1'b1;
      @(negedge clk);
      check("reset_release", sample(), {1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0});

      // 2 and 3: write then read back
      do_txn(1'b1, 16'h0012, 16'hBEEF, 0, 1'b0, 16'h0, 16'h0, "wr_beef");
      do_txn(1'b0, 16'h0012, 16'h3C3C, 0, 1'b0, 16'h0, 16'h0, "rd_beef");
      idle(1, "t3");

      // 4: write at top address, then read it with valid held high across the write
      d2 = 16'($urandom);
      do_txn(1'b1, 16'hFFFF, 16'h1234, 2, 1'b0, 16'hFFFF, d2, "wr_ffff");
      do_txn(1'b0, 16'hFFFF, d2, 0, 1'b0, 16'h0, 16'h0, "rd_ffff");
      idle(2, "t4");

      // 5: noisy inputs while busy
      do_txn(1'b1, 16'h00A5, 16'h5A5A, 1, 1'b0, 16'h0, 16'h0, "wr_noise");
      do_txn(1'b0, 16'h00A5, 16'h0F0F, 1, 1'b0, 16'h0, 16'h0, "rd_noise");
      idle(1, "t5");

      // 6: reset during the write pulse
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0777; req_data = 16'hCAFE;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (S) @(negedge clk);
      check("abort_pulse", sample(), {1'b0, 1'b0, 1'b0, 1'b1, 16'h0777, 16'hCAFE, exp_rdata});
      #1 nrst = 1'b0;
      #1 check("abort_async", sample(), {1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0});
      exp_rdata = '0; cur_addr = '0; cur_wdata = '0;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("abort_release", sample(), {1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0});
      do_txn(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 16'h0, 16'h0, "rd_after_abort");

      // Random traffic against the scoreboard
      for (int i = 0; i < 24; i++) begin
         logic        wr;
         logic [15:0] a;
         wr = 1'($urandom);
         a  = addrs[$urandom_range(0, 4)];
         if (!wr && !exp_mem.exists(a)) wr = 1'b1;
         do_txn(wr, a, 16'($urandom), int'($urandom_range(0, 1)), 1'b0, 16'h0, 16'h0,
                $sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), $sformatf("rnd%0d", i));
      end

      total++;
      assert (overlap === 0) else begin
         bad++;
         $error("FAIL strobe_overlap observed=%0d expected=0", overlap);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
